// File: rtl/inst_mem_axi_slave_pkg.sv
// Shared definitions for the instruction-memory AXI read slave: FSM states,
// RRESP/ARBURST/ARSIZE codes and the WRAP length legality helper.
package inst_mem_axi_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_DATA  = 2'b10
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [2:0] SIZE_WORD = 3'b010;

  // WRAP bursts are only legal for 2, 4, 8 or 16 beats
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/bram_1r1w.sv
// Single-clock RAM with one write and one read port; registered read output,
// read-first when both ports address the same word in the same cycle.
module bram_1r1w #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4096
) (
  input  logic                     CLK,
  input  logic                     WE,
  input  logic [$clog2(DEPTH)-1:0] WADDR,
  input  logic [WIDTH-1:0]         WDATA,
  input  logic                     RE,
  input  logic [$clog2(DEPTH)-1:0] RADDR,
  output logic [WIDTH-1:0]         RDATA
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Storage write and enabled read; output holds while RE is low
  always_ff @(posedge CLK) begin
    if (WE) mem_r[WADDR] <= WDATA;
    if (RE) RDATA <= mem_r[RADDR];
  end

endmodule

// File: rtl/inst_mem_axi_slave.sv
// AXI4 read-only slave over a program-loadable instruction RAM.
// Define INST_MEM_WRAP_BURST_EN to accept WRAP bursts; otherwise they answer SLVERR.
module inst_mem_axi_slave
  import inst_mem_axi_slave_pkg::*;
#(
  parameter int          C_S_AXI_THREAD_ID_WIDTH = 1,
  parameter int          C_S_AXI_ADDR_WIDTH      = 32,
  parameter int          C_S_AXI_DATA_WIDTH      = 32,
  parameter int          C_S_AXI_ARUSER_WIDTH    = 1,
  parameter int          C_S_AXI_RUSER_WIDTH     = 4,
  parameter logic [31:0] MEM_BASE                = 32'h2000_0000,
  parameter int          MEM_WORDS               = 4096
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic                               LOAD_WE,
  input  logic [$clog2(MEM_WORDS)-1:0]       LOAD_ADDR,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]      LOAD_DATA,
  input  logic [C_S_AXI_THREAD_ID_WIDTH-1:0] S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_ARADDR,
  input  logic [7:0]                         S_AXI_ARLEN,
  input  logic [2:0]                         S_AXI_ARSIZE,
  input  logic [1:0]                         S_AXI_ARBURST,
  input  logic [1:0]                         S_AXI_ARLOCK,
  input  logic [3:0]                         S_AXI_ARCACHE,
  input  logic [2:0]                         S_AXI_ARPROT,
  input  logic [3:0]                         S_AXI_ARQOS,
  input  logic [C_S_AXI_ARUSER_WIDTH-1:0]    S_AXI_ARUSER,
  input  logic                               S_AXI_ARVALID,
  output logic                               S_AXI_ARREADY,
  output logic [C_S_AXI_THREAD_ID_WIDTH-1:0] S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_RDATA,
  output logic [1:0]                         S_AXI_RRESP,
  output logic                               S_AXI_RLAST,
  output logic [C_S_AXI_RUSER_WIDTH-1:0]     S_AXI_RUSER,
  output logic                               S_AXI_RVALID,
  input  logic                               S_AXI_RREADY
);

  localparam int                          AW      = C_S_AXI_ADDR_WIDTH;
  localparam int                          IDX_W   = $clog2(MEM_WORDS);
  localparam logic [AW-1:0]               BASE_L  = AW'(MEM_BASE);
  localparam logic [AW:0]                 BYTES_L = (AW+1)'(4 * MEM_WORDS);

  state_e                               state_r, state_nxt_s;
  logic [AW-1:0]                        addr_r, next_addr_s, iss_addr_s, off_s, wrap_mask_s, addr_inc_s;
  logic [7:0]                           len_r, beat_r, iss_len_s, iss_beat_s;
  logic [1:0]                           burst_r, rresp_r, iss_resp_s;
  logic                                 err_r, ar_err_s, burst_bad_s, iss_err_s, issue_s, in_range_s;
  logic                                 arready_r, rvalid_r, rlast_r;
  logic [C_S_AXI_THREAD_ID_WIDTH-1:0]   rid_r;
  logic [C_S_AXI_DATA_WIDTH-1:0]        ram_dout_s;
  logic                                 unused_s;

  // Legality of a new request's size and burst type
  always_comb begin
    burst_bad_s = 1'b0;
    case (S_AXI_ARBURST)
      BURST_FIXED, BURST_INCR: burst_bad_s = 1'b0;
      BURST_WRAP: begin
`ifdef INST_MEM_WRAP_BURST_EN
        burst_bad_s = !wrap_len_ok(S_AXI_ARLEN);
`else
        burst_bad_s = 1'b1;
`endif
      end
      default: burst_bad_s = 1'b1;
    endcase
    ar_err_s = (S_AXI_ARSIZE != SIZE_WORD) || burst_bad_s;
  end

  // Address of the following beat; WRAP mask is (LEN+1)*4-1 for the legal lengths
  always_comb begin
    addr_inc_s  = addr_r + AW'(4);
    wrap_mask_s = AW'({len_r, 2'b11});
    next_addr_s = addr_inc_s;
    case (burst_r)
      BURST_FIXED: next_addr_s = addr_r;
      BURST_INCR:  next_addr_s = addr_inc_s;
      BURST_WRAP:  next_addr_s = (addr_r & ~wrap_mask_s) | (addr_inc_s & wrap_mask_s);
      default:     next_addr_s = addr_inc_s;
    endcase
  end

  // Next state and RAM read issue
  always_comb begin
    state_nxt_s = state_r;
    issue_s     = 1'b0;
    iss_addr_s  = addr_r;
    iss_beat_s  = beat_r;
    iss_len_s   = len_r;
    iss_err_s   = err_r;
    case (state_r)
      ST_IDLE: begin
        if (arready_r && S_AXI_ARVALID) begin
          state_nxt_s = ST_FETCH;
          issue_s     = 1'b1;
          iss_addr_s  = S_AXI_ARADDR;
          iss_beat_s  = 8'd0;
          iss_len_s   = S_AXI_ARLEN;
          iss_err_s   = ar_err_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FETCH: state_nxt_s = ST_DATA;
      ST_DATA: begin
        if (S_AXI_RREADY && (beat_r == len_r)) begin
          state_nxt_s = ST_IDLE;
        end else if (S_AXI_RREADY) begin
          issue_s    = 1'b1;
          iss_addr_s = next_addr_s;
          iss_beat_s = beat_r + 8'd1;
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Window decode and response for the beat being issued; burst errors take priority
  always_comb begin
    off_s      = iss_addr_s - BASE_L;
    in_range_s = (iss_addr_s >= BASE_L) && ({1'b0, off_s} < BYTES_L);
    if (iss_err_s) begin
      iss_resp_s = RESP_SLVERR;
    end else if (!in_range_s) begin
      iss_resp_s = RESP_DECERR;
    end else begin
      iss_resp_s = RESP_OKAY;
    end
  end

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_r <= ST_IDLE;
    else      state_r <= state_nxt_s;
  end

  // Burst context and registered channel outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rlast_r   <= 1'b0;
      rresp_r   <= RESP_OKAY;
      rid_r     <= '0;
      addr_r    <= '0;
      beat_r    <= 8'd0;
      len_r     <= 8'd0;
      burst_r   <= BURST_FIXED;
      err_r     <= 1'b0;
    end else begin
      arready_r <= (state_nxt_s == ST_IDLE);
      rvalid_r  <= (state_nxt_s == ST_DATA);
      if (issue_s) begin
        addr_r  <= iss_addr_s;
        beat_r  <= iss_beat_s;
        len_r   <= iss_len_s;
        err_r   <= iss_err_s;
        rresp_r <= iss_resp_s;
        rlast_r <= (iss_beat_s == iss_len_s);
      end
      if (issue_s && (state_r == ST_IDLE)) begin
        rid_r   <= S_AXI_ARID;
        burst_r <= S_AXI_ARBURST;
      end
    end
  end

  bram_1r1w #(
    .WIDTH (C_S_AXI_DATA_WIDTH),
    .DEPTH (MEM_WORDS)
  ) u_ram (
    .CLK   (CLK),
    .WE    (LOAD_WE),
    .WADDR (LOAD_ADDR),
    .WDATA (LOAD_DATA),
    .RE    (issue_s),
    .RADDR (off_s[IDX_W+1:2]),
    .RDATA (ram_dout_s)
  );

  // Error beats and idle cycles present zero data
  assign S_AXI_RDATA   = (rvalid_r && (rresp_r == RESP_OKAY)) ? ram_dout_s : {C_S_AXI_DATA_WIDTH{1'b0}};
  assign S_AXI_ARREADY = arready_r;
  assign S_AXI_RVALID  = rvalid_r;
  assign S_AXI_RLAST   = rlast_r;
  assign S_AXI_RRESP   = rresp_r;
  assign S_AXI_RID     = rid_r;
  assign S_AXI_RUSER   = {C_S_AXI_RUSER_WIDTH{1'b0}};

  assign unused_s = ^{S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS, S_AXI_ARUSER, off_s};

endmodule

// File: tb/tb_inst_mem_axi_slave.sv
// Self-checking bench for inst_mem_axi_slave: directed scenarios plus random
// bursts scored against a word-array model of the address map.
module tb_inst_mem_axi_slave;

  localparam int          MEM_WORDS = 4096;
  localparam logic [31:0] BASE      = 32'h2000_0000;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        LOAD_WE = 1'b0;
  logic [11:0] LOAD_ADDR = 12'd0;
  logic [31:0] LOAD_DATA = 32'd0;
  logic [0:0]  ARID = 1'b0;
  logic [31:0] ARADDR = 32'd0;
  logic [7:0]  ARLEN = 8'd0;
  logic [2:0]  ARSIZE = 3'd2;
  logic [1:0]  ARBURST = 2'd1;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [0:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic [3:0]  RUSER;
  logic        RVALID;
  logic        RREADY = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_mem [MEM_WORDS];
  logic [31:0] exp_data_q [$];
  logic [1:0]  exp_resp_q [$];

  always #5 CLK = ~CLK;

  inst_mem_axi_slave dut (
    .CLK(CLK), .RST(RST),
    .LOAD_WE(LOAD_WE), .LOAD_ADDR(LOAD_ADDR), .LOAD_DATA(LOAD_DATA),
    .S_AXI_ARID(ARID), .S_AXI_ARADDR(ARADDR), .S_AXI_ARLEN(ARLEN),
    .S_AXI_ARSIZE(ARSIZE), .S_AXI_ARBURST(ARBURST), .S_AXI_ARLOCK(2'b00),
    .S_AXI_ARCACHE(4'h0), .S_AXI_ARPROT(3'b000), .S_AXI_ARQOS(4'h0),
    .S_AXI_ARUSER(1'b0), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
    .S_AXI_RID(RID), .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP),
    .S_AXI_RLAST(RLAST), .S_AXI_RUSER(RUSER), .S_AXI_RVALID(RVALID),
    .S_AXI_RREADY(RREADY)
  );

  // Expected beats derived from the address-map rules
  function automatic void build_expect(input logic [31:0] a0, input logic [7:0] len,
                                       input logic [2:0] size, input logic [1:0] burst);
    bit          err;
    int unsigned bytes;
    logic [31:0] a, wbase;
    exp_data_q.delete();
    exp_resp_q.delete();
    bytes = (int'(len) + 1) * 4;
    err   = (size != 3'd2) || (burst == 2'd3);
    if (burst == 2'd2) begin
`ifdef INST_MEM_WRAP_BURST_EN
      if (!(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) err = 1'b1;
`else
      err = 1'b1;
`endif
    end
    wbase = a0 - (a0 % bytes);
    for (int i = 0; i <= int'(len); i++) begin
      if (burst == 2'd0)      a = a0;
      else if (burst == 2'd1) a = a0 + 32'(4 * i);
      else                    a = wbase + ((a0 - wbase + 32'(4 * i)) % bytes);
      if (err) begin
        exp_data_q.push_back(32'd0); exp_resp_q.push_back(2'b10);
      end else if (a < BASE || a >= BASE + 32'(4 * MEM_WORDS)) begin
        exp_data_q.push_back(32'd0); exp_resp_q.push_back(2'b11);
      end else begin
        exp_data_q.push_back(model_mem[(a - BASE) >> 2]); exp_resp_q.push_back(2'b00);
      end
    end
  endfunction

  task automatic do_ar(input string name, input logic [0:0] id, input logic [31:0] addr,
                       input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                       output bit ok);
    int n = 0;
    @(negedge CLK);
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    while (ARREADY !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    n_checks++;
    if (n >= 20) begin
      n_fail++;
      $display("FAIL %s ar_timeout: ARREADY=%b required 1 within 20 cycles", name, ARREADY);
      ARVALID = 1'b0;
      ok = 1'b0;
      return;
    end
    @(posedge CLK);
    @(negedge CLK);
    ARVALID = 1'b0;
    n_checks++;
    if (RVALID !== 1'b0 || ARREADY !== 1'b0) begin
      n_fail++;
      $display("FAIL %s fetch_cycle: RVALID=%b ARREADY=%b required 0 0", name, RVALID, ARREADY);
    end
    ok = 1'b1;
  endtask

  // rr_mode: 0 RREADY held high, 1 toggling starting low, 2 random
  task automatic run_burst(input string name, input logic [0:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                           input int rr_mode, input int inj_beat, input logic [11:0] inj_addr,
                           input logic [31:0] inj_data);
    bit ok;
    int beat = 0;
    int cyc  = 0;
    build_expect(addr, len, size, burst);
    do_ar(name, id, addr, len, size, burst, ok);
    if (!ok) return;
    while (beat <= int'(len) && cyc < 200) begin
      @(negedge CLK);
      LOAD_WE = 1'b0;
      if (rr_mode == 0)      RREADY = 1'b1;
      else if (rr_mode == 1) RREADY = (cyc % 2 == 1);
      else                   RREADY = 1'($urandom_range(0, 1));
      if (cyc == 0) begin
        n_checks++;
        if (RVALID !== 1'b1) begin
          n_fail++;
          $display("FAIL %s first_beat_latency: RVALID=%b required 1 at handshake+2", name, RVALID);
        end
      end
      if (RVALID === 1'b1) begin
        n_checks++;
        if (RDATA !== exp_data_q[beat] || RRESP !== exp_resp_q[beat] || RID !== id ||
            RLAST !== (beat == int'(len)) || RUSER !== 4'd0) begin
          n_fail++;
          $display("FAIL %s beat%0d: data=%h resp=%b id=%b last=%b user=%h required data=%h resp=%b id=%b last=%b user=0",
                   name, beat, RDATA, RRESP, RID, RLAST, RUSER, exp_data_q[beat], exp_resp_q[beat],
                   id, (beat == int'(len)));
        end
        if (RREADY) begin
          if (beat == inj_beat) begin
            LOAD_WE = 1'b1; LOAD_ADDR = inj_addr; LOAD_DATA = inj_data;
          end
          beat++;
        end
      end else if (rr_mode == 0 && cyc > 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s beat_gap: RVALID=%b required 1 with RREADY held", name, RVALID);
      end
      cyc++;
    end
    if (beat <= int'(len)) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s r_timeout: beats=%0d required %0d", name, beat, int'(len) + 1);
    end
    @(negedge CLK);
    LOAD_WE = 1'b0;
    RREADY  = 1'b0;
    if (inj_beat >= 0) model_mem[inj_addr] = inj_data;
    n_checks++;
    if (ARREADY !== 1'b1 || RVALID !== 1'b0) begin
      n_fail++;
      $display("FAIL %s return_idle: ARREADY=%b RVALID=%b required 1 0", name, ARREADY, RVALID);
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    n_checks++;
    if (ARREADY !== 1'b0 || RVALID !== 1'b0 || RLAST !== 1'b0 || RID !== 1'b0 ||
        RDATA !== 32'd0 || RRESP !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_values: arready=%b rvalid=%b rlast=%b rid=%b rdata=%h rresp=%b required all 0",
               ARREADY, RVALID, RLAST, RID, RDATA, RRESP);
    end
    RST = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (ARREADY !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: ARREADY=%b required 1", ARREADY);
    end
  endtask

  task automatic load_memory();
    for (int i = 0; i < MEM_WORDS; i++) begin
      @(negedge CLK);
      model_mem[i] = (i < 4) ? (32'hA0 + 32'(i)) : $urandom;
      LOAD_WE = 1'b1; LOAD_ADDR = 12'(i); LOAD_DATA = model_mem[i];
    end
    @(negedge CLK);
    LOAD_WE = 1'b0;
  endtask

  task automatic test_incr();
    run_burst("incr_stream", 1'b1, BASE, 8'd3, 3'd2, 2'd1, 0, -1, 12'd0, 32'd0);
    run_burst("incr_toggle", 1'b0, BASE, 8'd3, 3'd2, 2'd1, 1, -1, 12'd0, 32'd0);
    run_burst("fixed", 1'b1, BASE + 32'd4, 8'd2, 3'd2, 2'd0, 0, -1, 12'd0, 32'd0);
  endtask

  task automatic test_wrap();
    run_burst("wrap_len3", 1'b0, BASE + 32'd8, 8'd3, 3'd2, 2'd2, 0, -1, 12'd0, 32'd0);
    run_burst("wrap_len2_illegal", 1'b1, BASE + 32'd8, 8'd2, 3'd2, 2'd2, 0, -1, 12'd0, 32'd0);
    run_burst("burst_reserved", 1'b0, BASE, 8'd1, 3'd2, 2'd3, 0, -1, 12'd0, 32'd0);
  endtask

  task automatic test_errors();
    run_burst("top_boundary", 1'b1, BASE + 32'(4 * MEM_WORDS) - 32'd4, 8'd1, 3'd2, 2'd1, 0, -1, 12'd0, 32'd0);
    run_burst("decerr_low", 1'b0, 32'h1000_0000, 8'd0, 3'd2, 2'd1, 0, -1, 12'd0, 32'd0);
    run_burst("slverr_size", 1'b1, BASE, 8'd2, 3'd1, 2'd1, 0, -1, 12'd0, 32'd0);
  endtask

  task automatic test_mid_reset();
    bit ok;
    int beat = 0;
    int cyc  = 0;
    build_expect(BASE, 8'd7, 3'd2, 2'd1);
    do_ar("mid_reset", 1'b1, BASE, 8'd7, 3'd2, 2'd1, ok);
    if (!ok) return;
    RREADY = 1'b1;
    while (beat < 2 && cyc < 20) begin
      @(negedge CLK);
      if (RVALID === 1'b1) beat++;
      cyc++;
    end
    @(negedge CLK);
    RST = 1'b0;
    RREADY = 1'b0;
    #1;
    n_checks++;
    if (RVALID !== 1'b0 || ARREADY !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_abort: RVALID=%b ARREADY=%b required 0 0", RVALID, ARREADY);
    end
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (ARREADY !== 1'b1 || RVALID !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_release: ARREADY=%b RVALID=%b required 1 0", ARREADY, RVALID);
    end
    run_burst("after_reset", 1'b0, BASE, 8'd3, 3'd2, 2'd1, 0, -1, 12'd0, 32'd0);
  endtask

  task automatic test_read_first();
    run_burst("read_first", 1'b1, BASE, 8'd3, 3'd2, 2'd1, 0, 0, 12'd1, 32'h0000_BEEF);
    run_burst("reread_new", 1'b0, BASE, 8'd3, 3'd2, 2'd1, 0, -1, 12'd0, 32'd0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [2:0]  sz;
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 9))
        0:       a = BASE - 32'($urandom_range(1, 64));
        1:       a = BASE + 32'(4 * MEM_WORDS) - 32'($urandom_range(1, 40));
        default: a = BASE + 32'($urandom_range(0, MEM_WORDS - 1) * 4) + 32'($urandom_range(0, 3));
      endcase
      sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
      run_burst("random", 1'($urandom_range(0, 1)), a, 8'($urandom_range(0, 15)), sz,
                2'($urandom_range(0, 3)), 2, -1, 12'd0, 32'd0);
    end
  endtask

  initial begin
    test_reset();
    load_memory();
    test_incr();
    test_wrap();
    test_errors();
    test_mid_reset();
    test_read_first();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
